// File: rtl/nn_pkg.sv
// nn_pkg: shared defaults, sequencer state and default-width result entry for the digit network
package nn_pkg;
  localparam int DATA_W_DEF      = 16;
  localparam int OUT_CLASSES_DEF = 10;
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} seq_state_t;
  function automatic int clog2_min1(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic [0:0]                         img;
    logic [$clog2(OUT_CLASSES_DEF)-1:0] cls;
  } res_entry_t;
endpackage

// File: rtl/nn_res_fifo.sv
// nn_res_fifo: first-word fall-through result FIFO; a push into a full FIFO is taken only alongside a pop
module nn_res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign rd      = pop_i & ~empty_o;
  assign wr      = push_i & (~full_o | rd);
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge clk) if (wr) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr);
      rd_q  <= rd_q + AW'(rd);
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/nn_infer_seq.sv
// nn_infer_seq: streams NUM_IMAGES images from memory into the network and queues each class
// result with its image index; single-pass or continuous runs, stop at set boundaries, result timeout.
module nn_infer_seq
  import nn_pkg::*;
#(
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  OUT_CLASSES = OUT_CLASSES_DEF,
  parameter int  NUM_IMAGES  = 1,
  parameter int  RES_DEPTH   = 4,
  parameter int  TIMEOUT     = 4096,
  localparam int OUT_W       = $clog2(OUT_CLASSES),
  localparam int IMG_W       = clog2_min1(NUM_IMAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  output logic              mem_ren,
  output logic [IMG_W-1:0]  mem_img,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_last,
  output logic              net_valid,
  output logic [DATA_W-1:0] net_data,
  input  logic              net_out_valid,
  input  logic [OUT_W-1:0]  net_out_data,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_data,
  output logic [IMG_W-1:0]  res_img,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              timeout,
  output logic [3:0]        led
);
  localparam int               TW       = clog2_min1(TIMEOUT + 1);
  localparam logic [IMG_W-1:0] LAST_IMG = IMG_W'(NUM_IMAGES - 1);
  typedef struct packed {
    logic [IMG_W-1:0] img;
    logic [OUT_W-1:0] cls;
  } res_t;
  seq_state_t        state_q;
  logic              start_q, stop_req_q, done_q, overflow_q, timeout_q, net_valid_q;
  logic [IMG_W-1:0]  img_q;
  logic [TW-1:0]     tcnt_q;
  logic [DATA_W-1:0] net_data_q;
  logic [3:0]        led_q;
  logic              start_edge, push, pop, full, empty, expired;
  res_t              res_in, res_out;
  assign start_edge = start & ~start_q;
  assign push       = (state_q == WAIT_RES) & net_out_valid;
  assign pop        = ~empty & res_ready;
  assign expired    = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT));
  assign res_in     = '{img: img_q, cls: net_out_data};
  assign mem_ren    = state_q == STREAM;
  assign mem_img    = img_q;
  assign net_valid  = net_valid_q;
  assign net_data   = net_data_q;
  assign res_valid  = ~empty;
  assign res_data   = res_out.cls;
  assign res_img    = res_out.img;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
  assign led        = led_q;
  nn_res_fifo #(.W($bits(res_t)), .DEPTH(RES_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (res_in),
    .pop_i   (pop),
    .data_o  (res_out),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      stop_req_q  <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      net_valid_q <= 1'b0;
      net_data_q  <= '0;
      img_q       <= '0;
      tcnt_q      <= '0;
      led_q       <= '0;
    end else begin
      start_q     <= start;
      net_valid_q <= mem_valid;
      net_data_q  <= mem_data;
      done_q      <= 1'b0;
      if (push && full && !pop) overflow_q <= 1'b1;
      if (state_q != IDLE && stop) stop_req_q <= 1'b1;
      case (state_q)
        IDLE: if (start_edge) begin
          state_q    <= STREAM;
          img_q      <= '0;
          overflow_q <= 1'b0;
          timeout_q  <= 1'b0;
          stop_req_q <= 1'b0;
        end
        STREAM: if (mem_valid && mem_last) begin
          state_q <= WAIT_RES;
          tcnt_q  <= '0;
        end
        WAIT_RES: begin
          tcnt_q <= tcnt_q + 1'b1;
          // a result arriving on the expiry cycle still counts
          if (net_out_valid) begin
            led_q <= 4'(net_out_data);
            if (img_q < LAST_IMG) begin
              img_q   <= img_q + 1'b1;
              state_q <= STREAM;
            end else if (cont && !stop_req_q) begin
              img_q   <= '0;
              state_q <= STREAM;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
